downstream_req_gen: RTL and testbench
=====================================

DOWNSTREAM_REQ_GEN -- requirements
Module: downstream_req_gen

Interface
REQ-001 The block SHALL have parameter ID_W, default 5, meaning client ID width in bits.
REQ-002 The block SHALL have parameter AMT_W, default 16, meaning amount width in bits.
REQ-003 The block SHALL have parameter NCH, default 2, meaning the number of input channels, legal range 1..8.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning per-channel FIFO entries, a power of two >= 2.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port in_valid, input, NCH bits: per-channel update valid.
REQ-008 The block SHALL have port in_client_id, input, NCH*ID_W bits: channel c occupies bits [c*ID_W +: ID_W].
REQ-009 The block SHALL have port in_amount, input, NCH*AMT_W bits: channel c occupies bits [c*AMT_W +: AMT_W].
REQ-010 The block SHALL have port in_ready, output, NCH bits: per-channel update accept.
REQ-011 The block SHALL have port req_valid, output, 1 bit: downstream write request valid.
REQ-012 The block SHALL have port req_ready, input, 1 bit: downstream memory accepts the request.
REQ-013 The block SHALL have port req_wrindex, output, ID_W bits: client ID to write.
REQ-014 The block SHALL have port req_amount, output, AMT_W bits: amount to write.
REQ-015 The block SHALL have port req_we, output, 1 bit: write enable, equal to req_valid.
REQ-016 The block SHALL have port req_ch, output, clog2(NCH) bits (min 1): source channel of the request.
REQ-017 The block SHALL have port dup_count, output, 16 bits: saturating count of suppressed duplicate updates, all channels.

Function
REQ-018 An update SHALL be accepted on channel c at an edge where in_valid[c] and in_ready[c] are both 1.
REQ-019 in_ready[c] SHALL be combinationally equal to NOT full of FIFO c; it does not depend on a same-cycle pop.
REQ-020 Each channel SHALL hold shadow state: shadow_vld, shadow_id and shadow_amt.
REQ-021 An accepted update SHALL be a change when shadow_vld==0, or when ID differs from shadow_id, or when amount differs from shadow_amt.
REQ-022 A change SHALL push {id, amount} into FIFO c on the accepting edge.
REQ-023 A non-change SHALL push nothing and SHALL increment dup_count by 1, saturating at 0xFFFF.
REQ-024 Simultaneous duplicates on k channels in one cycle SHALL add k to dup_count, saturating at 0xFFFF.
REQ-025 Every accepted update, change or not, SHALL load shadow_id and shadow_amt and set shadow_vld=1 on the accepting edge.
REQ-026 The output stage SHALL be a single register.
  - It loads when req_valid==0 or req_ready==1, from the next non-empty FIFO in round-robin order starting at rr_ptr.
  - Loading pops that FIFO.
  - rr_ptr then becomes (granted channel + 1) mod NCH.
  - If no FIFO is non-empty, req_valid goes to 0.
REQ-027 While req_valid==1 and req_ready==0, req_wrindex, req_amount, req_ch and req_we SHALL hold stable.
REQ-028 Latency SHALL be exactly 2 edges from the accepting edge to req_valid=1 when the output and all FIFOs are idle: the push happens on edge N, the load on edge N+1.
REQ-029 A push and a pop on the same FIFO at the same edge SHALL both take effect; the occupancy is unchanged.
REQ-030 FIFO read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-031 Requests from one channel SHALL leave the block in acceptance order.
REQ-032 No change event SHALL be lost or duplicated.

Reset
REQ-033 While rst_n==0, independent of clk, the following SHALL be cleared:
  - req_valid, req_we, req_wrindex, req_amount, req_ch: all 0.
  - dup_count = 0, rr_ptr = 0.
  - All FIFOs empty, all shadow_vld = 0.
  - in_ready = all 1s.
REQ-034 Reset asserted mid-operation SHALL discard queued and in-flight requests without emitting them.
REQ-035 After reset, the first update on each channel SHALL always be treated as a change.

Verification
REQ-036 The bench SHALL cover: reset, then ch0 update id=3, amt=100 -> req_valid=1 exactly 2 edges later with wrindex=3, amount=100, req_ch=0, we=1.
REQ-037 The bench SHALL cover: a repeat of ch0 id=3, amt=100 -> no request; dup_count=1. Then id=3, amt=101 -> one request with amount=101.
REQ-038 The bench SHALL cover: NCH=2, same cycle ch0 id=1 and ch1 id=2, req_ready=1 -> requests in order ch0 then ch1; rr_ptr=0 after the second grant.
REQ-039 The bench SHALL cover: req_ready=0, ch0 issues DEPTH+1 distinct updates -> in_ready[0]=0 after DEPTH+1 accepted (1 in output, DEPTH queued); the output holds stable. Then req_ready=1 -> all DEPTH+1 emitted in order.
REQ-040 The bench SHALL cover: 0xFFFF+3 duplicate updates -> dup_count saturates at 0xFFFF.
REQ-041 The bench SHALL cover: rst_n low mid-stall with 3 queued requests -> req_valid drops immediately, no request after release, and the next update with previous values is treated as a change.

Source files
------------

// File: rtl/downstream_req_gen_if.sv
// -----------------------------------------------------------------------------
// downstream_req_gen_if
// Bundles the update inputs, the downstream write-request bus and the
// duplicate counter of downstream_req_gen.
//   in_valid/in_client_id/in_amount/in_ready : per-channel update handshake
//   req_valid/req_ready/req_wrindex/req_amount/req_we/req_ch : write request
//   dup_count : saturating count of suppressed duplicate updates
// Modports:
//   slave  - the block's view (consumes updates, issues requests)
//   master - the environment's view (produces updates, accepts requests)
// -----------------------------------------------------------------------------
interface downstream_req_gen_if #(
   parameter int ID_W  = 5,
   parameter int AMT_W = 16,
   parameter int NCH   = 2
);
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]       in_valid;
   logic [NCH*ID_W-1:0]  in_client_id;
   logic [NCH*AMT_W-1:0] in_amount;
   logic [NCH-1:0]       in_ready;
   logic                 req_valid;
   logic                 req_ready;
   logic [ID_W-1:0]      req_wrindex;
   logic [AMT_W-1:0]     req_amount;
   logic                 req_we;
   logic [CH_W-1:0]      req_ch;
   logic [15:0]          dup_count;

   modport slave (
      input  in_valid, in_client_id, in_amount, req_ready,
      output in_ready, req_valid, req_wrindex, req_amount, req_we, req_ch, dup_count
   );

   modport master (
      output in_valid, in_client_id, in_amount, req_ready,
      input  in_ready, req_valid, req_wrindex, req_amount, req_we, req_ch, dup_count
   );
endinterface

// File: rtl/downstream_req_gen.sv
// -----------------------------------------------------------------------------
// downstream_req_gen
// Filters per-channel {client id, amount} updates against a per-channel shadow
// copy, queues only real changes in a per-channel FIFO and drains the FIFOs
// round-robin into a single registered downstream write request.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - downstream_req_gen_if.slave (update inputs, request bus, dup_count)
// -----------------------------------------------------------------------------
module downstream_req_gen #(
   parameter int ID_W  = 5,
   parameter int AMT_W = 16,
   parameter int NCH   = 2,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   downstream_req_gen_if.slave   bus
);
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW   = $clog2(DEPTH);

   logic [ID_W-1:0]  mem_id  [NCH][DEPTH];
   logic [AMT_W-1:0] mem_amt [NCH][DEPTH];
   // One extra pointer bit separates full from empty.
   logic [PW:0]      wr_ptr  [NCH];
   logic [PW:0]      rd_ptr  [NCH];

   logic [NCH-1:0]   shadow_vld;
   logic [ID_W-1:0]  shadow_id  [NCH];
   logic [AMT_W-1:0] shadow_amt [NCH];

   logic [CH_W-1:0]  rr_ptr;
   logic             out_vld;
   logic [ID_W-1:0]  out_id;
   logic [AMT_W-1:0] out_amt;
   logic [CH_W-1:0]  out_ch;
   logic [15:0]      dup_cnt;

   logic [NCH-1:0]   full;
   logic [NCH-1:0]   empty;
   logic [NCH-1:0]   accept;
   logic [NCH-1:0]   change;
   logic [NCH-1:0]   push;
   logic [NCH-1:0]   dup;
   logic [3:0]       dup_n;
   logic [16:0]      dup_sum;
   logic             load;
   logic             grant_vld;
   logic [CH_W-1:0]  grant_ch;
   logic [CH_W-1:0]  cand;

   // Per-channel acceptance and change detection
   always_comb begin
      dup_n = '0;
      for (int c = 0; c < NCH; c++) begin
         full[c]   = (wr_ptr[c][PW] != rd_ptr[c][PW]) &&
                     (wr_ptr[c][PW-1:0] == rd_ptr[c][PW-1:0]);
         empty[c]  = (wr_ptr[c] == rd_ptr[c]);
         accept[c] = bus.in_valid[c] & ~full[c];
         change[c] = !shadow_vld[c] ||
                     (bus.in_client_id[c*ID_W +: ID_W] != shadow_id[c]) ||
                     (bus.in_amount[c*AMT_W +: AMT_W] != shadow_amt[c]);
         push[c]   = accept[c] & change[c];
         dup[c]    = accept[c] & ~change[c];
         dup_n     = dup_n + 4'(dup[c]);
      end
      dup_sum = {1'b0, dup_cnt} + 17'(dup_n);
   end

   // Round-robin search starting at rr_ptr; the output register may load
   // whenever it is empty or its current request is being taken.
   always_comb begin
      grant_vld = 1'b0;
      grant_ch  = '0;
      cand      = '0;
      for (int i = 0; i < NCH; i++) begin
         cand = CH_W'((int'(rr_ptr) + i) % NCH);
         if (!grant_vld && !empty[cand]) begin
            grant_vld = 1'b1;
            grant_ch  = cand;
         end
      end
      load = !out_vld || bus.req_ready;
   end

   // Control and output register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
         end
         shadow_vld <= '0;
         rr_ptr     <= '0;
         out_vld    <= 1'b0;
         out_id     <= '0;
         out_amt    <= '0;
         out_ch     <= '0;
         dup_cnt    <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (push[c])
               wr_ptr[c] <= wr_ptr[c] + (PW+1)'(1);
            if (load && grant_vld && (grant_ch == CH_W'(c)))
               rd_ptr[c] <= rd_ptr[c] + (PW+1)'(1);
         end
         shadow_vld <= shadow_vld | accept;
         if (load) begin
            out_vld <= grant_vld;
            if (grant_vld) begin
               out_id  <= mem_id[grant_ch][rd_ptr[grant_ch][PW-1:0]];
               out_amt <= mem_amt[grant_ch][rd_ptr[grant_ch][PW-1:0]];
               out_ch  <= grant_ch;
               rr_ptr  <= CH_W'((int'(grant_ch) + 1) % NCH);
            end
         end
         dup_cnt <= dup_sum[16] ? 16'hFFFF : dup_sum[15:0];
      end
   end

   // FIFO storage and shadow data carry no reset; validity lives in the
   // pointers and shadow_vld.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (push[c]) begin
            mem_id[c][wr_ptr[c][PW-1:0]]  <= bus.in_client_id[c*ID_W +: ID_W];
            mem_amt[c][wr_ptr[c][PW-1:0]] <= bus.in_amount[c*AMT_W +: AMT_W];
         end
         if (accept[c]) begin
            shadow_id[c]  <= bus.in_client_id[c*ID_W +: ID_W];
            shadow_amt[c] <= bus.in_amount[c*AMT_W +: AMT_W];
         end
      end
   end

   assign bus.in_ready    = ~full;
   assign bus.req_valid   = out_vld;
   assign bus.req_we      = out_vld;
   assign bus.req_wrindex = out_id;
   assign bus.req_amount  = out_amt;
   assign bus.req_ch      = out_ch;
   assign bus.dup_count   = dup_cnt;
endmodule

// File: tb/tb_downstream_req_gen.sv
// -----------------------------------------------------------------------------
// tb_downstream_req_gen
// Directed scenarios followed by randomized traffic, checked every cycle
// against a queue-based behavioural model of the request generator.
// -----------------------------------------------------------------------------
module tb_downstream_req_gen;
   localparam int ID_W  = 5;
   localparam int AMT_W = 16;
   localparam int NCH   = 2;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [AMT_W-1:0] amt;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   downstream_req_gen_if #(.ID_W(ID_W), .AMT_W(AMT_W), .NCH(NCH)) bus ();

   downstream_req_gen #(.ID_W(ID_W), .AMT_W(AMT_W), .NCH(NCH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural model: per-channel change queues, one output slot,
   // a round-robin start index and a saturating duplicate counter.
   ent_t mq [NCH][$];
   bit   m_vld = 1'b0;
   int   m_id = 0, m_amt = 0, m_ch = 0, m_rr = 0, m_dup = 0;
   bit   sh_vld [NCH];
   int   sh_id  [NCH];
   int   sh_amt [NCH];
   bit   m_acc  [NCH];
   bit   found;
   int   g;
   ent_t e;

   function automatic void chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function void model_reset();
      for (int c = 0; c < NCH; c++) begin
         mq[c].delete();
         sh_vld[c] = 1'b0;
         sh_id[c]  = 0;
         sh_amt[c] = 0;
      end
      m_vld = 1'b0;
      m_rr  = 0;
      m_dup = 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int c = 0; c < NCH; c++)
            m_acc[c] = bus.in_valid[c] && (mq[c].size() < DEPTH);
         if (!m_vld || bus.req_ready) begin
            found = 1'b0;
            for (int i = 0; i < NCH; i++) begin
               g = (m_rr + i) % NCH;
               if (!found && mq[g].size() > 0) begin
                  found = 1'b1;
                  e     = mq[g].pop_front();
                  m_id  = int'(e.id);
                  m_amt = int'(e.amt);
                  m_ch  = g;
                  m_rr  = (g + 1) % NCH;
               end
            end
            m_vld = found;
         end
         for (int c = 0; c < NCH; c++) begin
            if (m_acc[c]) begin
               e.id  = bus.in_client_id[c*ID_W +: ID_W];
               e.amt = bus.in_amount[c*AMT_W +: AMT_W];
               if (!sh_vld[c] || int'(e.id) != sh_id[c] || int'(e.amt) != sh_amt[c])
                  mq[c].push_back(e);
               else if (m_dup < 65535)
                  m_dup++;
               sh_vld[c] = 1'b1;
               sh_id[c]  = int'(e.id);
               sh_amt[c] = int'(e.amt);
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("req_valid", int'(bus.req_valid), int'(m_vld));
         chk("req_we", int'(bus.req_we), int'(m_vld));
         if (m_vld) begin
            chk("req_wrindex", int'(bus.req_wrindex), m_id);
            chk("req_amount", int'(bus.req_amount), m_amt);
            chk("req_ch", int'(bus.req_ch), m_ch);
         end
         for (int c = 0; c < NCH; c++)
            chk("in_ready", int'(bus.in_ready[c]), int'(mq[c].size() < DEPTH));
         chk("dup_count", int'(bus.dup_count), m_dup);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(int c, int id, int amt);
      bus.in_client_id[c*ID_W +: ID_W]  = ID_W'(id);
      bus.in_amount[c*AMT_W +: AMT_W]   = AMT_W'(amt);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      bus.in_valid     = '0;
      bus.in_client_id = '0;
      bus.in_amount    = '0;
      bus.req_ready    = 1'b1;
      rst_n            = 1'b0;
      repeat (3) tick();
      chk("rst_req_valid", int'(bus.req_valid), 0);
      chk("rst_req_we", int'(bus.req_we), 0);
      chk("rst_wrindex", int'(bus.req_wrindex), 0);
      chk("rst_amount", int'(bus.req_amount), 0);
      chk("rst_req_ch", int'(bus.req_ch), 0);
      chk("rst_in_ready", int'(bus.in_ready), 3);
      chk("rst_dup", int'(bus.dup_count), 0);
      rst_n = 1'b1;
      tick();

      // First update: push on edge N, visible after edge N+1
      set_in(0, 3, 100);
      bus.in_valid = 2'b01;
      tick();
      bus.in_valid = '0;
      chk("lat_edge_n", int'(bus.req_valid), 0);
      tick();
      chk("lat_valid", int'(bus.req_valid), 1);
      chk("lat_wrindex", int'(bus.req_wrindex), 3);
      chk("lat_amount", int'(bus.req_amount), 100);
      chk("lat_ch", int'(bus.req_ch), 0);
      chk("lat_we", int'(bus.req_we), 1);
      chk("model_lat_vld", int'(m_vld), 1);
      tick();
      chk("lat_drain", int'(bus.req_valid), 0);

      // Duplicate then an amount change
      bus.in_valid = 2'b01;
      tick();
      bus.in_valid = '0;
      tick();
      chk("dup_no_req", int'(bus.req_valid), 0);
      chk("dup_count1", int'(bus.dup_count), 1);
      chk("model_dup1", m_dup, 1);
      set_in(0, 3, 101);
      bus.in_valid = 2'b01;
      tick();
      bus.in_valid = '0;
      tick();
      chk("chg_valid", int'(bus.req_valid), 1);
      chk("chg_amount", int'(bus.req_amount), 101);
      tick();

      // Two channels in the same cycle, round-robin from 0
      do_reset();
      set_in(0, 1, 7);
      set_in(1, 2, 8);
      bus.in_valid = 2'b11;
      tick();
      bus.in_valid = '0;
      tick();
      chk("rr_first_ch", int'(bus.req_ch), 0);
      chk("rr_first_id", int'(bus.req_wrindex), 1);
      tick();
      chk("rr_second_ch", int'(bus.req_ch), 1);
      chk("rr_second_id", int'(bus.req_wrindex), 2);
      chk("rr_ptr", int'(dut.rr_ptr), 0);
      chk("model_rr", m_rr, 0);
      tick();

      // Stall: DEPTH+1 distinct updates fill output plus FIFO
      bus.req_ready = 1'b0;
      for (int k = 0; k <= DEPTH; k++) begin
         set_in(0, 10 + k, 200 + k);
         bus.in_valid = 2'b01;
         tick();
      end
      bus.in_valid = '0;
      chk("stall_in_ready0", int'(bus.in_ready[0]), 0);
      chk("stall_in_ready1", int'(bus.in_ready[1]), 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_valid", int'(bus.req_valid), 1);
         chk("stall_wrindex", int'(bus.req_wrindex), 10);
         chk("stall_amount", int'(bus.req_amount), 200);
      end
      bus.req_ready = 1'b1;
      for (int k = 0; k <= DEPTH; k++) begin
         chk("drain_valid", int'(bus.req_valid), 1);
         chk("drain_wrindex", int'(bus.req_wrindex), 10 + k);
         tick();
      end
      chk("drain_done", int'(bus.req_valid), 0);

      // Saturation: two duplicates per cycle after the first edge
      do_reset();
      set_in(0, 4, 4);
      set_in(1, 5, 5);
      bus.in_valid = 2'b11;
      for (int t = 1; t <= 32770; t++) begin
         tick();
         if (t == 32768)
            chk("sat_before", int'(bus.dup_count), 65534);
      end
      bus.in_valid = '0;
      chk("sat_dup", int'(bus.dup_count), 65535);
      chk("model_sat", m_dup, 65535);
      tick();

      // Reset mid-stall with queued requests
      do_reset();
      bus.req_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_in(0, 20 + k, 5);
         bus.in_valid = 2'b01;
         tick();
      end
      bus.in_valid = '0;
      tick();
      chk("pre_rst_valid", int'(bus.req_valid), 1);
      chk("pre_rst_wrindex", int'(bus.req_wrindex), 20);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", int'(bus.req_valid), 0);
      chk("async_rst_in_ready", int'(bus.in_ready), 3);
      chk("async_rst_dup", int'(bus.dup_count), 0);
      tick();
      tick();
      rst_n = 1'b1;
      bus.req_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("post_rst_idle", int'(bus.req_valid), 0);
      end
      set_in(0, 23, 5);
      bus.in_valid = 2'b01;
      tick();
      bus.in_valid = '0;
      tick();
      chk("post_rst_chg_valid", int'(bus.req_valid), 1);
      chk("post_rst_chg_id", int'(bus.req_wrindex), 23);
      chk("post_rst_chg_amt", int'(bus.req_amount), 5);
      tick();

      // Randomized traffic with narrow value ranges to provoke duplicates
      for (int t = 0; t < 3000; t++) begin
         bus.in_valid = NCH'($urandom_range(0, (1 << NCH) - 1));
         for (int c = 0; c < NCH; c++)
            set_in(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
         bus.req_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 299) == 0) begin
            #2 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
         tick();
      end
      bus.in_valid = '0;
      bus.req_ready = 1'b1;
      repeat (12) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
